// File: rtl/instr_fetch_decode_pkg.sv
// Shared encodings for the fetch/decode front end:
// register selects, opcodes, ALU ops and fetch FSM states.
package instr_fetch_decode_pkg;

  localparam logic [1:0] NSEL_RN = 2'b00;
  localparam logic [1:0] NSEL_RD = 2'b01;
  localparam logic [1:0] NSEL_RM = 2'b10;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [2:0] OPC_LDR = 3'b011;
  localparam logic [2:0] OPC_STR = 3'b100;
  localparam logic [2:0] OPC_HLT = 3'b111;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_CMP = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MVN = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10,
    S_FULL = 2'b11
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_decode_decoder.sv
// Combinational field extraction from IR:
// opcode/op/shift, nsel register index and sign-extended immediates.
module instr_decoder
  import instr_fetch_decode_pkg::*;
(
  input  logic [15:0] ir,
  input  logic [1:0]  nsel,
  output logic [2:0]  opcode,
  output logic [1:0]  op,
  output logic [1:0]  shift,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign shift  = ir[4:3];
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};

  always_comb begin
    readnum = 3'b000;
    unique case (1'b1)
      nsel == NSEL_RN: readnum = ir[10:8];
      nsel == NSEL_RD: readnum = ir[7:5];
      nsel == NSEL_RM: readnum = ir[2:0];
      default:         readnum = 3'b000;
    endcase
  end

  assign writenum = readnum;

endmodule

// File: rtl/instr_fetch_decode.sv
// Front end: PC, one-entry fetch buffer, IR and the
// memory-port fetch FSM, with decode of IR.
module instr_fetch_decode
  import instr_fetch_decode_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int PC_RESET = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              loadpc,
  input  logic              loadir,
  input  logic              msel,
  input  logic [1:0]        nsel,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       ir,
  output logic [2:0]        opcode,
  output logic [1:0]        op,
  output logic [1:0]        shift,
  output logic [2:0]        readnum,
  output logic [2:0]        writenum,
  output logic [15:0]       sximm8,
  output logic [15:0]       sximm5,
  output logic              instr_ready,
  output logic              loadir_err
);

  fetch_state_e state, nxt;
  logic [15:0] buffer;
  logic abort, abort_nxt;
  logic buf_en, ir_en, err_set;

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_REQ;
    else       state <= nxt;

  // loadpc always wins; a request already in flight is
  // drained via abort so its response cannot fill the buffer
  always_comb begin
    nxt       = state;
    abort_nxt = abort;
    buf_en    = 1'b0;
    mem_req   = 1'b0;
    unique case (state)
      S_IDLE: if (loadpc) nxt = S_REQ;
      S_REQ: begin
        if (loadpc) nxt = S_REQ;
        else if (!msel) begin
          mem_req = 1'b1;
          nxt     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          abort_nxt = 1'b0;
          if (abort || loadpc) nxt = S_REQ;
          else begin
            buf_en = 1'b1;
            nxt    = S_FULL;
          end
        end else if (loadpc) abort_nxt = 1'b1;
      end
      S_FULL: begin
        if (loadpc)      nxt = S_REQ;
        else if (loadir) nxt = S_IDLE;
      end
      default: nxt = S_REQ;
    endcase
    if (reset) mem_req = 1'b0;
  end

  assign ir_en       = loadir && (state == S_FULL);
  assign err_set     = loadir && (state != S_FULL);
  assign instr_ready = (state == S_FULL);
  assign mem_addr    = msel ? c_addr : pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc         <= ADDR_W'(PC_RESET);
      ir         <= 16'h0000;
      buffer     <= 16'h0000;
      abort      <= 1'b0;
      loadir_err <= 1'b0;
    end else begin
      if (loadpc)  pc         <= pc + 1'b1;
      if (ir_en)   ir         <= buffer;
      if (buf_en)  buffer     <= mem_rdata;
      if (err_set) loadir_err <= 1'b1;
      abort <= abort_nxt;
    end
  end

  instr_decoder u_dec (
    .ir       (ir),
    .nsel     (nsel),
    .opcode   (opcode),
    .op       (op),
    .shift    (shift),
    .readnum  (readnum),
    .writenum (writenum),
    .sximm8   (sximm8),
    .sximm5   (sximm5)
  );

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode: fetch, decode,
// PC wrap, abort on refetch, msel arbitration, loadir error.
module tb_instr_fetch_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic        loadpc, loadir, msel;
  logic [1:0]  nsel;
  logic [7:0]  c_addr;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_req;
  logic [7:0]  mem_addr, pc;
  logic [15:0] ir;
  logic [2:0]  opcode;
  logic [1:0]  op, shift;
  logic [2:0]  readnum, writenum;
  logic [15:0] sximm8, sximm5;
  logic        instr_ready, loadir_err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  instr_fetch_decode #(.ADDR_W(8), .PC_RESET(0)) dut (
    .clk(clk), .reset(reset), .loadpc(loadpc), .loadir(loadir),
    .msel(msel), .nsel(nsel), .c_addr(c_addr),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .mem_req(mem_req), .mem_addr(mem_addr), .pc(pc), .ir(ir),
    .opcode(opcode), .op(op), .shift(shift),
    .readnum(readnum), .writenum(writenum),
    .sximm8(sximm8), .sximm5(sximm5),
    .instr_ready(instr_ready), .loadir_err(loadir_err)
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // from IDLE: loadpc, answer the fetch one cycle later, loadir
  task automatic fetch(input logic [15:0] d, input logic [7:0] a);
    loadpc = 1'b1;
    step();
    loadpc = 1'b0;
    #1;
    chk("fetch_req", {15'b0, mem_req}, 16'h0001);
    chk("fetch_addr", {8'b0, mem_addr}, {8'b0, a});
    step();
    mem_rvalid = 1'b1;
    mem_rdata  = d;
    step();
    mem_rvalid = 1'b0;
    loadir     = 1'b1;
    step();
    loadir = 1'b0;
    #1;
    chk("fetch_ir", ir, d);
  endtask

  initial begin
    reset = 1'b1; loadpc = 1'b0; loadir = 1'b0; msel = 1'b0;
    nsel = 2'b00; c_addr = 8'h00; mem_rdata = 16'h0000;
    mem_rvalid = 1'b0;
    #1;
    chk("rst_req", {15'b0, mem_req}, 16'h0000);
    chk("rst_pc", {8'b0, pc}, 16'h0000);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_rdy", {15'b0, instr_ready}, 16'h0000);
    chk("rst_err", {15'b0, loadir_err}, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;

    // 1: first fetch after reset
    chk("t1_req", {15'b0, mem_req}, 16'h0001);
    chk("t1_addr", {8'b0, mem_addr}, 16'h0000);
    step();
    chk("t1_req_pulse", {15'b0, mem_req}, 16'h0000);
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hD105;
    step();
    mem_rvalid = 1'b0;
    #1;
    chk("t1_ready", {15'b0, instr_ready}, 16'h0001);
    loadir = 1'b1;
    step();
    loadir = 1'b0;
    #1;
    chk("t1_ir", ir, 16'hD105);
    chk("t1_opcode", {13'b0, opcode}, 16'h0006);
    chk("t1_op", {14'b0, op}, 16'h0002);
    chk("t1_sximm8", sximm8, 16'h0005);
    chk("t1_idle", {15'b0, instr_ready}, 16'h0000);

    // 2: register selects
    fetch(16'hA0A3, 8'h01);
    nsel = 2'b00; #1;
    chk("t2_rn", {13'b0, readnum}, 16'h0000);
    chk("t2_rn_w", {13'b0, writenum}, 16'h0000);
    nsel = 2'b01; #1;
    chk("t2_rd", {13'b0, readnum}, 16'h0005);
    chk("t2_rd_w", {13'b0, writenum}, 16'h0005);
    nsel = 2'b10; #1;
    chk("t2_rm", {13'b0, readnum}, 16'h0003);
    chk("t2_rm_w", {13'b0, writenum}, 16'h0003);
    nsel = 2'b11; #1;
    chk("t2_rsv", {13'b0, readnum}, 16'h0000);
    nsel = 2'b00;

    // 3: sign extension
    fetch(16'h6080, 8'h02);
    chk("t3_sx8", sximm8, 16'hFF80);
    chk("t3_sx5_zero", sximm5, 16'h0000);
    fetch(16'h0010, 8'h03);
    chk("t3_sx5", sximm5, 16'hFFF0);
    chk("t3_sx8_pos", sximm8, 16'h0010);
    chk("t3_shift", {14'b0, shift}, 16'h0002);

    // 4: PC wrap
    loadpc = 1'b1;
    repeat (252) step();
    chk("t4_pc_ff", {8'b0, pc}, 16'h00FF);
    chk("t4_noreq", {15'b0, mem_req}, 16'h0000);
    step();
    loadpc = 1'b0;
    #1;
    chk("t4_pc_wrap", {8'b0, pc}, 16'h0000);
    chk("t4_req", {15'b0, mem_req}, 16'h0001);
    chk("t4_addr", {8'b0, mem_addr}, 16'h0000);

    // 5: loadpc while waiting discards the in-flight response
    step();
    loadpc = 1'b1;
    step();
    loadpc = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hBEEF;
    #1;
    chk("t5_wait_noreq", {15'b0, mem_req}, 16'h0000);
    step();
    mem_rvalid = 1'b0;
    #1;
    chk("t5_not_ready", {15'b0, instr_ready}, 16'h0000);
    chk("t5_req", {15'b0, mem_req}, 16'h0001);
    chk("t5_addr", {8'b0, mem_addr}, 16'h0001);
    step();
    mem_rvalid = 1'b1;
    mem_rdata  = 16'h1234;
    step();
    mem_rvalid = 1'b0;
    #1;
    chk("t5_ready", {15'b0, instr_ready}, 16'h0001);
    loadir = 1'b1;
    loadpc = 1'b1;
    step();
    loadir = 1'b0;
    loadpc = 1'b0;
    #1;
    chk("t5_ir", ir, 16'h1234);
    chk("t5_pc", {8'b0, pc}, 16'h0002);
    chk("t5_refetch", {15'b0, mem_req}, 16'h0001);
    chk("t5_refetch_addr", {8'b0, mem_addr}, 16'h0002);

    // 6: data access holds off the fetch
    msel   = 1'b1;
    c_addr = 8'h40;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t6_daddr", {8'b0, mem_addr}, 16'h0040);
      chk("t6_noreq", {15'b0, mem_req}, 16'h0000);
      step();
    end
    msel = 1'b0;
    #1;
    chk("t6_req", {15'b0, mem_req}, 16'h0001);
    chk("t6_addr", {8'b0, mem_addr}, 16'h0002);
    step();
    mem_rvalid = 1'b1;
    mem_rdata  = 16'h5555;
    step();
    mem_rvalid = 1'b0;
    loadir     = 1'b1;
    step();
    loadir = 1'b0;
    #1;
    chk("t6_ir", ir, 16'h5555);
    chk("t6_err_clear", {15'b0, loadir_err}, 16'h0000);
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hFFFF;
    step();
    mem_rvalid = 1'b0;
    #1;
    chk("t6_idle_ignore", {15'b0, instr_ready}, 16'h0000);
    loadir = 1'b1;
    step();
    loadir = 1'b0;
    #1;
    chk("t6_err", {15'b0, loadir_err}, 16'h0001);
    chk("t6_ir_hold", ir, 16'h5555);
    step();
    chk("t6_err_sticky", {15'b0, loadir_err}, 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
